// File: rtl/multi_countdown_timer_pkg.sv
// Shared types and default sizing for the countdown timer bank.
// Each channel walks IDLE -> RUN <-> PAUSE -> DONE; start re-enters from anywhere.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } ch_state_t;

   localparam int DEF_NUM_CH   = 4;
   localparam int DEF_CNT_W    = 10;
   localparam int DEF_PRESCALE = 192;

endpackage

// File: rtl/multi_countdown_timer_if.sv
// Control/status bundle between the control FSMs (master) and the timer bank (slave).
interface multi_countdown_timer_if
   import timer_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W
);
   logic [NUM_CH-1:0]       start;
   logic [NUM_CH-1:0]       pause;
   logic [NUM_CH-1:0]       reload_mode;
   logic [NUM_CH*CNT_W-1:0] load_value;
   logic [NUM_CH*CNT_W-1:0] count;
   logic [NUM_CH-1:0]       running;
   logic [NUM_CH-1:0]       expired;
   logic [NUM_CH-1:0]       done_pulse;

   modport master (
      output start, pause, reload_mode, load_value,
      input  count, running, expired, done_pulse
   );

   modport slave (
      input  start, pause, reload_mode, load_value,
      output count, running, expired, done_pulse
   );
endinterface

// File: rtl/multi_countdown_timer_channel.sv
// One countdown timer: prescaled decrement, pause freeze, one-shot or auto-reload.
module countdown_channel
   import timer_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int PRE_W    = $clog2(PRESCALE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             reload_mode,
   input  logic [CNT_W-1:0] load_value,
   output logic [CNT_W-1:0] count,
   output logic             running,
   output logic             expired,
   output logic             done_pulse
);
   localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRESCALE - 1);

   ch_state_t        state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [PRE_W-1:0] pre_q, pre_n;
   logic [CNT_W-1:0] ld_q, ld_n;
   logic             mode_q, mode_n;
   logic             pulse_q, pulse_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pre_q   <= PRE_TOP;
         ld_q    <= '0;
         mode_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         pre_q   <= pre_n;
         ld_q    <= ld_n;
         mode_q  <= mode_n;
         pulse_q <= pulse_n;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      pre_n   = pre_q;
      ld_n    = ld_q;
      mode_n  = mode_q;
      pulse_n = 1'b0;
      if (start) begin
         ld_n   = load_value;
         mode_n = reload_mode;
         cnt_n  = load_value;
         pre_n  = PRE_TOP;
         if (load_value == '0) begin
            state_n = DONE;
            pulse_n = 1'b1;
         end else begin
            state_n = RUN;
         end
      end else begin
         case (state_q)
            RUN, PAUSE: begin
               // A zero count while active only occurs in auto-reload; reload even if paused.
               if (cnt_q == '0) begin
                  cnt_n   = ld_q;
                  pre_n   = PRE_TOP;
                  state_n = pause ? PAUSE : RUN;
               end else if (pause) begin
                  state_n = PAUSE;
               end else begin
                  state_n = RUN;
                  if (pre_q == '0) begin
                     pre_n = PRE_TOP;
                     cnt_n = cnt_q - CNT_W'(1);
                     if (cnt_q == CNT_W'(1)) begin
                        pulse_n = 1'b1;
                        if (!mode_q) state_n = DONE;
                     end
                  end else begin
                     pre_n = pre_q - PRE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign count      = cnt_q;
   assign running    = (state_q == RUN) || (state_q == PAUSE);
   assign expired    = (cnt_q == '0);
   assign done_pulse = pulse_q;
endmodule

// File: rtl/multi_countdown_timer.sv
// Bank of NUM_CH independent countdown timers; the top only slices and joins buses.
module multi_countdown_timer
   import timer_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input logic                  clk,
   input logic                  reset,
   multi_countdown_timer_if.slave bus
);
   localparam int PRE_W = $clog2(PRESCALE);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      countdown_channel #(
         .CNT_W    (CNT_W),
         .PRESCALE (PRESCALE),
         .PRE_W    (PRE_W)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .start       (bus.start[i]),
         .pause       (bus.pause[i]),
         .reload_mode (bus.reload_mode[i]),
         .load_value  (bus.load_value[i*CNT_W +: CNT_W]),
         .count       (bus.count[i*CNT_W +: CNT_W]),
         .running     (bus.running[i]),
         .expired     (bus.expired[i]),
         .done_pulse  (bus.done_pulse[i])
      );
   end
endmodule

// File: tb/tb_multi_countdown_timer.sv
// Directed bench for the timer bank at PRESCALE=4 with hand-computed expectations.
module tb_multi_countdown_timer;
   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 10;
   localparam int PRESCALE = 4;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   multi_countdown_timer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   multi_countdown_timer #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_load(input int ch, input logic [CNT_W-1:0] v);
      bus.load_value[ch*CNT_W +: CNT_W] = v;
   endtask

   function automatic logic [CNT_W-1:0] cnt(input int ch);
      return bus.count[ch*CNT_W +: CNT_W];
   endfunction

   int exp0 [14] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0};
   int exp1 [19] = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 2, 2, 2, 2, 1, 1, 1, 1, 0, 2};

   initial begin
      reset            = 1'b1;
      bus.start        = '0;
      bus.pause        = '0;
      bus.reload_mode  = '0;
      bus.load_value   = '0;
      repeat (3) tick();
      chk("rst_count",   bus.count,      0);
      chk("rst_expired", bus.expired,    4'b1111);
      chk("rst_running", bus.running,    0);
      chk("rst_done",    bus.done_pulse, 0);
      reset = 1'b0;
      tick();

      // ch0 one-shot, load 3
      set_load(0, 3);
      bus.reload_mode[0] = 1'b0;
      bus.start[0] = 1'b1;
      tick();
      bus.start[0] = 1'b0;
      for (int k = 0; k < 14; k++) begin
         chk($sformatf("os_cnt_%0d", k),  cnt(0), exp0[k]);
         chk($sformatf("os_done_%0d", k), bus.done_pulse[0], (k == 12));
         chk($sformatf("os_run_%0d", k),  bus.running[0], (k < 12));
         tick();
      end
      chk("os_expired", bus.expired[0], 1);

      // ch1 auto-reload, load 2: period 9 cycles
      set_load(1, 2);
      bus.reload_mode[1] = 1'b1;
      bus.start[1] = 1'b1;
      tick();
      bus.start[1] = 1'b0;
      for (int k = 0; k < 19; k++) begin
         chk($sformatf("ar_cnt_%0d", k),  cnt(1), exp1[k]);
         chk($sformatf("ar_done_%0d", k), bus.done_pulse[1], (k == 8 || k == 17));
         chk($sformatf("ar_run_%0d", k),  bus.running[1], 1);
         tick();
      end

      // ch2 load 5, pause with prescaler at 2
      set_load(2, 5);
      bus.reload_mode[2] = 1'b0;
      bus.start[2] = 1'b1;
      tick();
      bus.start[2] = 1'b0;
      chk("pz_load", cnt(2), 5);
      repeat (3) tick();
      chk("pz_pre_dec", cnt(2), 5);
      tick();
      chk("pz_dec1", cnt(2), 4);
      tick();
      bus.pause[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("pz_hold_%0d", k), cnt(2), 4);
         chk($sformatf("pz_run_%0d", k),  bus.running[2], 1);
      end
      bus.pause[2] = 1'b0;
      tick();
      chk("pz_rel1", cnt(2), 4);
      tick();
      chk("pz_rel2", cnt(2), 4);
      tick();
      chk("pz_rel3", cnt(2), 3);

      // ch3 zero load goes straight to DONE
      set_load(3, 0);
      bus.start[3] = 1'b1;
      tick();
      bus.start[3] = 1'b0;
      chk("z_cnt",     cnt(3), 0);
      chk("z_done",    bus.done_pulse[3], 1);
      chk("z_run",     bus.running[3], 0);
      chk("z_expired", bus.expired[3], 1);
      tick();
      chk("z_done_off", bus.done_pulse[3], 0);
      chk("z_run_off",  bus.running[3], 0);

      // ch0 start and pause in the same cycle: start wins, then freezes
      set_load(0, 6);
      bus.start[0] = 1'b1;
      bus.pause[0] = 1'b1;
      tick();
      bus.start[0] = 1'b0;
      chk("sp_cnt", cnt(0), 6);
      chk("sp_run", bus.running[0], 1);
      repeat (6) tick();
      chk("sp_hold", cnt(0), 6);
      chk("sp_run_hold", bus.running[0], 1);
      bus.pause[0] = 1'b0;

      // asynchronous reset mid-count on ch0
      set_load(0, 7);
      bus.start[0] = 1'b1;
      tick();
      bus.start[0] = 1'b0;
      tick();
      chk("ar0_cnt", cnt(0), 7);
      reset = 1'b1;
      #1;
      chk("arst_cnt",     cnt(0), 0);
      chk("arst_done",    bus.done_pulse, 0);
      chk("arst_run",     bus.running, 0);
      chk("arst_expired", bus.expired, 4'b1111);
      tick();
      chk("arst_done2", bus.done_pulse, 0);
      reset = 1'b0;
      tick();

      // restart ch0 with load 7; later load_value changes are ignored
      bus.reload_mode[0] = 1'b0;
      bus.start[0] = 1'b1;
      tick();
      bus.start[0] = 1'b0;
      set_load(0, 100);
      chk("rs_load", cnt(0), 7);
      repeat (3) tick();
      chk("rs_pre", cnt(0), 7);
      tick();
      chk("rs_dec", cnt(0), 6);
      chk("rs_done", bus.done_pulse[0], 0);
      chk("rs_run", bus.running[0], 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
